// File: rtl/issue_select.sv
// Issue-select stage: picks the oldest operand-ready entry of a 4-slot issue window each cycle,
// resolves operands against the two wake-up ports and hands the op to execute through one latch.
module issue_select #(
  parameter int unsigned PAYLOAD_W = 160,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   bco_valid,
  input  logic [3:0]             win_valid,
  input  logic [15:0]            win_src0_rob,
  input  logic [3:0]             win_src0_rdy,
  input  logic [127:0]           win_src0_value,
  input  logic [15:0]            win_src1_rob,
  input  logic [3:0]             win_src1_rdy,
  input  logic [127:0]           win_src1_value,
  input  logic [3:0]             win_pipe_mul,
  input  logic [3:0]             win_pipe_mem,
  input  logic [4*PAYLOAD_W-1:0] win_payload,
  input  logic                   web,
  input  logic [3:0]             dinb_rob,
  input  logic [31:0]            dinb_value,
  input  logic                   wec,
  input  logic [3:0]             dinc_rob,
  input  logic [31:0]            dinc_value,
  output logic [3:0]             wed,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [31:0]            iss_src0_value,
  output logic [31:0]            iss_src1_value,
  output logic                   iss_mul,
  output logic [PAYLOAD_W-1:0]   iss_payload
);

  localparam int unsigned CntW = $clog2(MUL_LAT) + 1;

  logic [CntW-1:0] mul_cnt;
  logic [3:0]      hit0b, hit0c, hit1b, hit1c;
  logic [3:0]      rdy0, rdy1, elig;
  logic [31:0]     val0 [4];
  logic [31:0]     val1 [4];
  logic            latch_free;
  logic            older_mem;
  logic            pick_any;
  logic [1:0]      pick_idx;

  always_comb begin
    latch_free = ~iss_valid | iss_ready;
    older_mem  = 1'b0;
    hit0b      = '0;
    hit0c      = '0;
    hit1b      = '0;
    hit1c      = '0;
    rdy0       = '0;
    rdy1       = '0;
    elig       = '0;
    for (int j = 0; j < 4; j++) begin
      hit0b[j] = web & (dinb_rob == win_src0_rob[j*4 +: 4]);
      hit0c[j] = wec & (dinc_rob == win_src0_rob[j*4 +: 4]);
      hit1b[j] = web & (dinb_rob == win_src1_rob[j*4 +: 4]);
      hit1c[j] = wec & (dinc_rob == win_src1_rob[j*4 +: 4]);
      rdy0[j]  = win_src0_rdy[j] | hit0b[j] | hit0c[j];
      rdy1[j]  = win_src1_rdy[j] | hit1b[j] | hit1c[j];
      // Window value first, then wake-up port 0, then port 1.
      val0[j]  = win_src0_rdy[j] ? win_src0_value[j*32 +: 32] :
                 hit0b[j]        ? dinb_value : dinc_value;
      val1[j]  = win_src1_rdy[j] ? win_src1_value[j*32 +: 32] :
                 hit1b[j]        ? dinb_value : dinc_value;
      elig[j]  = resetn & win_valid[j] & rdy0[j] & rdy1[j]
               & (~win_pipe_mul[j] | (mul_cnt == '0))
               & (~win_pipe_mem[j] | ~older_mem)
               & latch_free & ~bco_valid;
      // Any valid mem op, ready or not, blocks younger mem ops.
      older_mem = older_mem | (win_valid[j] & win_pipe_mem[j]);
    end
  end

  always_comb begin
    wed      = '0;
    pick_any = 1'b0;
    pick_idx = '0;
    for (int j = 0; j < 4; j++) begin
      if (elig[j] && !pick_any) begin
        pick_any = 1'b1;
        pick_idx = 2'(j);
        wed[j]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iss_valid      <= 1'b0;
      iss_src0_value <= '0;
      iss_src1_value <= '0;
      iss_mul        <= 1'b0;
      iss_payload    <= '0;
      mul_cnt        <= '0;
    end else begin
      if (bco_valid) begin
        iss_valid <= 1'b0;
      end else if (pick_any) begin
        iss_valid      <= 1'b1;
        iss_src0_value <= val0[pick_idx];
        iss_src1_value <= val1[pick_idx];
        iss_mul        <= win_pipe_mul[pick_idx];
        iss_payload    <= win_payload[pick_idx*PAYLOAD_W +: PAYLOAD_W];
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
      // Flush does not free the multiplier; it keeps counting down.
      if (pick_any && win_pipe_mul[pick_idx]) begin
        mul_cnt <= CntW'(MUL_LAT - 1);
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: oldest-ready pick, wake-up bypass, backpressure,
// MUL occupancy, mem ordering, flush and asynchronous reset.
module tb_issue_select;

  localparam int unsigned PW = 160;

  logic            clk = 1'b0;
  logic            resetn;
  logic            bco_valid;
  logic [3:0]      win_valid, win_src0_rdy, win_src1_rdy, win_pipe_mul, win_pipe_mem;
  logic [15:0]     win_src0_rob, win_src1_rob;
  logic [127:0]    win_src0_value, win_src1_value;
  logic [4*PW-1:0] win_payload;
  logic            web, wec;
  logic [3:0]      dinb_rob, dinc_rob;
  logic [31:0]     dinb_value, dinc_value;
  logic [3:0]      wed;
  logic            iss_valid, iss_ready, iss_mul;
  logic [31:0]     iss_src0_value, iss_src1_value;
  logic [PW-1:0]   iss_payload;

  int vectors = 0;
  int miscompares = 0;

  issue_select #(.PAYLOAD_W(PW), .MUL_LAT(3)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bco_valid      (bco_valid),
    .win_valid      (win_valid),
    .win_src0_rob   (win_src0_rob),
    .win_src0_rdy   (win_src0_rdy),
    .win_src0_value (win_src0_value),
    .win_src1_rob   (win_src1_rob),
    .win_src1_rdy   (win_src1_rdy),
    .win_src1_value (win_src1_value),
    .win_pipe_mul   (win_pipe_mul),
    .win_pipe_mem   (win_pipe_mem),
    .win_payload    (win_payload),
    .web            (web),
    .dinb_rob       (dinb_rob),
    .dinb_value     (dinb_value),
    .wec            (wec),
    .dinc_rob       (dinc_rob),
    .dinc_value     (dinc_value),
    .wed            (wed),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_src0_value (iss_src0_value),
    .iss_src1_value (iss_src1_value),
    .iss_mul        (iss_mul),
    .iss_payload    (iss_payload)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk_pl(input int unsigned j);
    logic [39:0] w;
    w = 40'h5A00000000 + 40'(j) * 40'h1111;
    return {4{w}};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_window;
    win_valid = '0; win_src0_rdy = '0; win_src1_rdy = '0;
    win_pipe_mul = '0; win_pipe_mem = '0;
    win_src0_rob = '0; win_src1_rob = '0;
    win_src0_value = '0; win_src1_value = '0; win_payload = '0;
    web = 1'b0; wec = 1'b0; dinb_rob = '0; dinc_rob = '0;
    dinb_value = '0; dinc_value = '0;
  endtask

  task automatic set_slot(input int j, input logic r0, input logic [3:0] t0,
                          input logic [31:0] v0, input logic r1, input logic [3:0] t1,
                          input logic [31:0] v1, input logic mul, input logic mem);
    win_valid[j]              = 1'b1;
    win_src0_rdy[j]           = r0;
    win_src0_rob[j*4 +: 4]    = t0;
    win_src0_value[j*32 +: 32] = v0;
    win_src1_rdy[j]           = r1;
    win_src1_rob[j*4 +: 4]    = t1;
    win_src1_value[j*32 +: 32] = v1;
    win_pipe_mul[j]           = mul;
    win_pipe_mem[j]           = mem;
    win_payload[j*PW +: PW]   = mk_pl(j);
  endtask

  task automatic drain;
    clear_window();
    iss_ready = 1'b1;
    bco_valid = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset;
    resetn = 1'b0; bco_valid = 1'b0; iss_ready = 1'b1;
    clear_window();
    set_slot(0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h12, 1'b0, 1'b0);
    #3;
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL reset_wed: got %b want 0000", wed);
    end
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", iss_valid);
    end
    vectors++;
    if (iss_payload !== '0 || iss_src0_value !== 32'h0 || iss_mul !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_latch: payload %h src0 %h mul %b want zeros", iss_payload,
               iss_src0_value, iss_mul);
    end
    step();
    clear_window();
    resetn = 1'b1;
    drain();
  endtask

  task automatic test_oldest_ready;
    set_slot(0, 1'b1, 4'd1, 32'h0000_0010, 1'b0, 4'd2, 32'h0, 1'b0, 1'b0);
    set_slot(1, 1'b0, 4'd3, 32'h0, 1'b1, 4'd4, 32'h0000_0011, 1'b0, 1'b0);
    set_slot(2, 1'b1, 4'd6, 32'h2222_0000, 1'b1, 4'd7, 32'h2222_0001, 1'b0, 1'b0);
    set_slot(3, 1'b1, 4'd8, 32'h3333_0000, 1'b1, 4'd10, 32'h3333_0001, 1'b0, 1'b0);
    #2;
    vectors++;
    if (wed !== 4'b0100) begin
      miscompares++; $display("FAIL oldest_wed: got %b want 0100", wed);
    end
    step();
    clear_window();
    vectors++;
    if (iss_valid !== 1'b1 || iss_payload !== mk_pl(2)) begin
      miscompares++;
      $display("FAIL oldest_latch: valid %b payload %h want 1 %h", iss_valid, iss_payload,
               mk_pl(2));
    end
    vectors++;
    if (iss_src0_value !== 32'h2222_0000 || iss_src1_value !== 32'h2222_0001) begin
      miscompares++;
      $display("FAIL oldest_vals: got %h %h want 22220000 22220001", iss_src0_value,
               iss_src1_value);
    end
    step();
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++; $display("FAIL oldest_drop: got %b want 0", iss_valid);
    end
    drain();
  endtask

  task automatic test_wakeup;
    set_slot(0, 1'b0, 4'd5, 32'h0, 1'b1, 4'd1, 32'h7, 1'b0, 1'b0);
    web = 1'b1; dinb_rob = 4'd5; dinb_value = 32'hDEAD_BEEF;
    #2;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL wake_b_wed: got %b want 0001", wed);
    end
    step();
    vectors++;
    if (iss_src0_value !== 32'hDEAD_BEEF || iss_src1_value !== 32'h7) begin
      miscompares++;
      $display("FAIL wake_b_vals: got %h %h want deadbeef 00000007", iss_src0_value,
               iss_src1_value);
    end
    web = 1'b0; wec = 1'b1; dinc_rob = 4'd5; dinc_value = 32'hCAFE_F00D;
    #2;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL wake_c_wed: got %b want 0001", wed);
    end
    step();
    vectors++;
    if (iss_src0_value !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL wake_c_val: got %h want cafef00d", iss_src0_value);
    end
    dinc_rob = 4'd6;
    #2;
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL wake_miss_wed: got %b want 0000", wed);
    end
    drain();
  endtask

  task automatic test_dual_match;
    set_slot(0, 1'b1, 4'd1, 32'h10, 1'b0, 4'd9, 32'h0, 1'b0, 1'b0);
    web = 1'b1; dinb_rob = 4'd9; dinb_value = 32'd1;
    wec = 1'b1; dinc_rob = 4'd9; dinc_value = 32'd2;
    #2;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL dual_wed: got %b want 0001", wed);
    end
    step();
    vectors++;
    if (iss_src1_value !== 32'd1 || iss_src0_value !== 32'h10) begin
      miscompares++;
      $display("FAIL dual_vals: got %h %h want 00000010 00000001", iss_src0_value,
               iss_src1_value);
    end
    drain();
  endtask

  task automatic test_backpressure;
    iss_ready = 1'b0;
    set_slot(0, 1'b1, 4'd1, 32'hA0, 1'b1, 4'd2, 32'hA1, 1'b0, 1'b0);
    #2;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL bp_first_wed: got %b want 0001", wed);
    end
    step();
    // Window now presents a different ready op in slot 0.
    win_src0_value[31:0] = 32'hB0;
    win_payload[PW-1:0]  = mk_pl(9);
    for (int c = 0; c < 3; c++) begin
      #2;
      vectors++;
      if (wed !== 4'b0000) begin
        miscompares++; $display("FAIL bp_hold_wed[%0d]: got %b want 0000", c, wed);
      end
      step();
      vectors++;
      if (iss_valid !== 1'b1 || iss_payload !== mk_pl(0) || iss_src0_value !== 32'hA0) begin
        miscompares++;
        $display("FAIL bp_hold_latch[%0d]: valid %b src0 %h payload %h want 1 a0 %h", c,
                 iss_valid, iss_src0_value, iss_payload, mk_pl(0));
      end
    end
    iss_ready = 1'b1;
    #2;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL bp_release_wed: got %b want 0001", wed);
    end
    step();
    vectors++;
    if (iss_valid !== 1'b1 || iss_payload !== mk_pl(9) || iss_src0_value !== 32'hB0) begin
      miscompares++;
      $display("FAIL bp_release_latch: valid %b src0 %h payload %h want 1 b0 %h", iss_valid,
               iss_src0_value, iss_payload, mk_pl(9));
    end
    drain();
  endtask

  task automatic test_mul;
    set_slot(0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b1, 1'b0);
    set_slot(1, 1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4, 1'b1, 1'b0);
    set_slot(2, 1'b1, 4'd6, 32'h5, 1'b1, 4'd7, 32'h6, 1'b0, 1'b0);
    #2;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL mul_t0_wed: got %b want 0001", wed);
    end
    step();
    win_valid[0] = 1'b0;
    vectors++;
    if (iss_mul !== 1'b1) begin
      miscompares++; $display("FAIL mul_t0_flag: got %b want 1", iss_mul);
    end
    #2;
    vectors++;
    if (wed !== 4'b0100) begin
      miscompares++; $display("FAIL mul_t1_wed: got %b want 0100", wed);
    end
    step();
    win_valid[2] = 1'b0;
    vectors++;
    if (iss_mul !== 1'b0 || iss_src0_value !== 32'h5) begin
      miscompares++;
      $display("FAIL mul_t1_latch: mul %b src0 %h want 0 00000005", iss_mul, iss_src0_value);
    end
    #2;
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL mul_t2_wed: got %b want 0000", wed);
    end
    step();
    #2;
    vectors++;
    if (wed !== 4'b0010) begin
      miscompares++; $display("FAIL mul_t3_wed: got %b want 0010", wed);
    end
    step();
    vectors++;
    if (iss_mul !== 1'b1 || iss_src0_value !== 32'h3) begin
      miscompares++;
      $display("FAIL mul_t3_latch: mul %b src0 %h want 1 00000003", iss_mul, iss_src0_value);
    end
    drain();
  endtask

  task automatic test_mem_order;
    set_slot(0, 1'b0, 4'd1, 32'h0, 1'b1, 4'd2, 32'h0, 1'b0, 1'b1);
    set_slot(1, 1'b1, 4'd3, 32'h0, 1'b1, 4'd4, 32'h0, 1'b0, 1'b1);
    #2;
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL mem_block_wed: got %b want 0000", wed);
    end
    set_slot(2, 1'b1, 4'd6, 32'h0, 1'b1, 4'd7, 32'h0, 1'b0, 1'b0);
    #2;
    vectors++;
    if (wed !== 4'b0100) begin
      miscompares++; $display("FAIL mem_alu_wed: got %b want 0100", wed);
    end
    drain();
  endtask

  task automatic test_bco;
    iss_ready = 1'b0;
    set_slot(0, 1'b1, 4'd1, 32'h0, 1'b1, 4'd2, 32'h0, 1'b0, 1'b0);
    step();
    vectors++;
    if (iss_valid !== 1'b1) begin
      miscompares++; $display("FAIL bco_setup: got %b want 1", iss_valid);
    end
    bco_valid = 1'b1;
    #2;
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL bco_wed: got %b want 0000", wed);
    end
    step();
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++; $display("FAIL bco_valid_drop: got %b want 0", iss_valid);
    end
    #2;
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL bco_wed_free: got %b want 0000", wed);
    end
    bco_valid = 1'b0;
    #1;
    vectors++;
    if (wed !== 4'b0001) begin
      miscompares++; $display("FAIL bco_after_wed: got %b want 0001", wed);
    end
    drain();
  endtask

  task automatic test_async_reset;
    iss_ready = 1'b0;
    set_slot(0, 1'b1, 4'd1, 32'h77, 1'b1, 4'd2, 32'h0, 1'b0, 1'b0);
    step();
    vectors++;
    if (iss_valid !== 1'b1) begin
      miscompares++; $display("FAIL areset_setup: got %b want 1", iss_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if (iss_valid !== 1'b0 || iss_payload !== '0 || iss_src0_value !== 32'h0) begin
      miscompares++;
      $display("FAIL areset_latch: valid %b src0 %h want 0 00000000", iss_valid,
               iss_src0_value);
    end
    vectors++;
    if (wed !== 4'b0000) begin
      miscompares++; $display("FAIL areset_wed: got %b want 0000", wed);
    end
    clear_window();
    step();
    resetn = 1'b1;
    step();
    vectors++;
    if (iss_valid !== 1'b0) begin
      miscompares++; $display("FAIL areset_release: got %b want 0", iss_valid);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_oldest_ready();
    test_wakeup();
    test_dual_match();
    test_backpressure();
    test_mul();
    test_mem_order();
    test_bco();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
